// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - VGA raster timing generator
// Drives pixel requests and the VGA pins, with sync and blanking delayed to match the pixel-source latency.
package vga_timing_pkg;
  typedef logic [11:0] color_t;
endpackage

module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_VIS    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_VIS    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int LAT      = 2
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] px_x,
  output logic [9:0] px_y,
  output logic       px_valid,
  output logic       px_tick,
  input  color_t     px_color,
  output logic       frame_start,
  output logic       vblank,
  output color_t     vga_color,
  output logic       vga_hs,
  output logic       vga_vs
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DL_N  = (LAT > 0) ? LAT : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]  H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOT - 1);
  localparam logic [10:0] H_VIS_L  = 11'(H_VIS);
  localparam logic [10:0] V_VIS_L  = 11'(V_VIS);
  localparam logic [10:0] HS_BEG   = 11'(H_VIS + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_VIS + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG   = 11'(V_VIS + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_VIS + V_FP + V_SYNC);
  localparam logic        ACT      = (SYNC_POL != 0);
  localparam logic [2:0]  DL_IDLE  = {~ACT, ~ACT, 1'b0};

  if (H_TOT > 1024 || V_TOT > 1024) begin : g_bad_totals
    $error("vga_timing: H_TOT or V_TOT does not fit the 10-bit counters");
  end
  if (CLK_DIV < 1 || LAT < 0 || LAT > 7) begin : g_bad_params
    $error("vga_timing: CLK_DIV must be >= 1 and LAT within 0..7");
  end

  logic [DIV_W-1:0]       div_q, div_d;
  logic [9:0]             h_q, h_d, v_q, v_d;
  logic [DL_N-1:0][2:0]   dl_q, dl_d;
  color_t                 color_q, color_d;
  logic                   hs_q, hs_d, vs_q, vs_d;
  logic                   hs_lvl, vs_lvl;
  logic [2:0]             raw, tap;

  // Gating with rst keeps tick and frame_start low while held in reset, even with CLK_DIV=1.
  assign px_tick     = (div_q == DIV_LAST) && !rst;
  assign px_x        = h_q;
  assign px_y        = v_q;
  assign px_valid    = ({1'b0, h_q} < H_VIS_L) && ({1'b0, v_q} < V_VIS_L);
  assign vblank      = ({1'b0, v_q} >= V_VIS_L);
  assign frame_start = px_tick && (h_q == 10'd0) && (v_q == 10'd0);

  assign hs_lvl = (({1'b0, h_q} >= HS_BEG) && ({1'b0, h_q} < HS_END)) ? ACT : ~ACT;
  assign vs_lvl = (({1'b0, v_q} >= VS_BEG) && ({1'b0, v_q} < VS_END)) ? ACT : ~ACT;
  assign raw    = {hs_lvl, vs_lvl, px_valid};
  assign tap    = (LAT == 0) ? raw : dl_q[DL_N-1];

  assign vga_color = color_q;
  assign vga_hs    = hs_q;
  assign vga_vs    = vs_q;

  always_comb begin
    div_d   = div_q;
    h_d     = h_q;
    v_d     = v_q;
    dl_d    = dl_q;
    color_d = color_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    if (px_tick) begin
      div_d = '0;
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
      dl_d[0] = raw;
      for (int i = 1; i < DL_N; i++) begin
        dl_d[i] = dl_q[i-1];
      end
      color_d = tap[0] ? px_color : '0;
      hs_d    = tap[2];
      vs_d    = tap[1];
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      dl_q    <= {DL_N{DL_IDLE}};
      color_q <= '0;
      hs_q    <= ~ACT;
      vs_q    <= ~ACT;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      dl_q    <= dl_d;
      color_q <= color_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - scoreboard bench for vga_timing
// Two instances share clk/rst: A (CLK_DIV=2, LAT=2, active-low sync) and B (CLK_DIV=1, LAT=0, active-high sync).
module tb_vga_timing;

  localparam int HV = 16, HF = 3, HSY = 4, HB = 5, HT = HV + HF + HSY + HB;
  localparam int VV = 8,  VF = 2, VSY = 2, VB = 3, VT = VV + VF + VSY + VB;

  typedef struct packed {
    logic [11:0] col;
    logic        hs;
    logic        vs;
    logic [9:0]  th;
    logic [9:0]  tv;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic white = 1'b0;

  logic [9:0]  ox [2];
  logic [9:0]  oy [2];
  logic [11:0] ocol [2];
  logic [11:0] pc [2];
  logic        ovalid [2], otick [2], ofs [2], ovb [2], ohs [2], ovs [2];
  logic [11:0] pipe_a [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  ent_t q0[$], q1[$];
  ent_t held [2];
  int   mdiv [2], mh [2], mv [2];
  bit   pend [2];

  int   hs_start [2], hs_per [2], hs_w [2];
  int   vs_start [2], vs_per [2], vs_w [2];
  int   fs_start [2], fs_per [2], fs_run [2], fs_wid [2], fs_cnt [2];
  bit   prev_hs [2], prev_vs [2];
  int   line_vis [2], blank_run [2], lines_seen [2], bad_lines [2], nz_cnt [2];
  logic [11:0] r5_col [2];
  bit   r5_seen [2];

  always #5 clk = ~clk;

  vga_timing #(
    .CLK_DIV(2), .H_VIS(HV), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB), .SYNC_POL(0), .LAT(2)
  ) dut_a (
    .clk(clk), .rst(rst), .px_x(ox[0]), .px_y(oy[0]), .px_valid(ovalid[0]),
    .px_tick(otick[0]), .px_color(pc[0]), .frame_start(ofs[0]), .vblank(ovb[0]),
    .vga_color(ocol[0]), .vga_hs(ohs[0]), .vga_vs(ovs[0])
  );

  vga_timing #(
    .CLK_DIV(1), .H_VIS(HV), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB), .SYNC_POL(1), .LAT(0)
  ) dut_b (
    .clk(clk), .rst(rst), .px_x(ox[1]), .px_y(oy[1]), .px_valid(ovalid[1]),
    .px_tick(otick[1]), .px_color(pc[1]), .frame_start(ofs[1]), .vblank(ovb[1]),
    .vga_color(ocol[1]), .vga_hs(ohs[1]), .vga_vs(ovs[1])
  );

  // Pixel sources: A answers two ticks late, B answers in the same tick.
  always @(posedge clk) begin
    if (otick[0]) begin
      pipe_a[0] <= white ? 12'hFFF : {ox[0][3:0], oy[0][3:0], 4'hA};
      pipe_a[1] <= pipe_a[0];
    end
  end
  assign pc[0] = pipe_a[1];
  assign pc[1] = white ? 12'hFFF : {ox[1][3:0], oy[1][3:0], 4'hA};

  function automatic int cdiv(int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic int lat(int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic logic pol(int d);
    return (d == 0) ? 1'b0 : 1'b1;
  endfunction

  function automatic ent_t blank_ent(int d);
    ent_t e;
    e.col = 12'h000;
    e.hs  = ~pol(d);
    e.vs  = ~pol(d);
    e.th  = 10'h3FF;
    e.tv  = 10'h3FF;
    return e;
  endfunction

  function automatic ent_t model_ent(int d, int h, int v);
    ent_t e;
    logic [9:0] hh, vv;
    hh = 10'(h);
    vv = 10'(v);
    e.th = hh;
    e.tv = vv;
    if (h < HV && v < VV) e.col = white ? 12'hFFF : {hh[3:0], vv[3:0], 4'hA};
    else                  e.col = 12'h000;
    e.hs = (h >= HV + HF && h < HV + HF + HSY) ? pol(d) : ~pol(d);
    e.vs = (v >= VV + VF && v < VV + VF + VSY) ? pol(d) : ~pol(d);
    return e;
  endfunction

  // One clock: advance the reference model for the coming edge, then compare at the falling edge.
  task automatic step();
    ent_t e;
    logic act;
    logic exp_tick;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        mdiv[d] = 0; mh[d] = 0; mv[d] = 0; pend[d] = 1'b0;
        if (d == 0) q0.delete(); else q1.delete();
        for (int i = 0; i < lat(d); i++) begin
          if (d == 0) q0.push_back(blank_ent(d)); else q1.push_back(blank_ent(d));
        end
        held[d] = blank_ent(d);
        hs_start[d] = -1; hs_per[d] = 0; hs_w[d] = 0;
        vs_start[d] = -1; vs_per[d] = 0; vs_w[d] = 0;
        fs_start[d] = -1; fs_per[d] = 0; fs_run[d] = 0; fs_wid[d] = 0; fs_cnt[d] = 0;
        prev_hs[d] = 1'b0; prev_vs[d] = 1'b0;
        line_vis[d] = 0; blank_run[d] = 0; lines_seen[d] = 0; bad_lines[d] = 0;
        r5_seen[d] = 1'b0;
      end else if (mdiv[d] == cdiv(d) - 1) begin
        e = model_ent(d, mh[d], mv[d]);
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        mdiv[d] = 0;
        pend[d] = 1'b1;
        if (mh[d] == HT - 1) begin
          mh[d] = 0;
          mv[d] = (mv[d] == VT - 1) ? 0 : mv[d] + 1;
        end else begin
          mh[d] = mh[d] + 1;
        end
      end else begin
        mdiv[d] = mdiv[d] + 1;
        pend[d] = 1'b0;
      end
    end

    @(negedge clk);
    cyc++;

    for (int d = 0; d < 2; d++) begin
      if (pend[d]) begin
        checks++;
        if ((d == 0 ? q0.size() : q1.size()) == 0) begin
          errors++;
          $display("FAIL scoreboard_empty dut%0d cyc %0d: got 0 entries, want at least 1", d, cyc);
        end else begin
          held[d] = (d == 0) ? q0.pop_front() : q1.pop_front();
        end
      end
      checks++;
      if (ocol[d] !== held[d].col) begin
        errors++;
        $display("FAIL vga_color dut%0d cyc %0d (x=%0d y=%0d): got %h want %h", d, cyc, held[d].th, held[d].tv, ocol[d], held[d].col);
      end
      checks++;
      if (ohs[d] !== held[d].hs) begin
        errors++;
        $display("FAIL vga_hs dut%0d cyc %0d: got %b want %b", d, cyc, ohs[d], held[d].hs);
      end
      checks++;
      if (ovs[d] !== held[d].vs) begin
        errors++;
        $display("FAIL vga_vs dut%0d cyc %0d: got %b want %b", d, cyc, ovs[d], held[d].vs);
      end
      exp_tick = (mdiv[d] == cdiv(d) - 1) && !rst;
      checks++;
      if (otick[d] !== exp_tick) begin
        errors++;
        $display("FAIL px_tick dut%0d cyc %0d: got %b want %b", d, cyc, otick[d], exp_tick);
      end
      checks++;
      if (ox[d] !== 10'(mh[d]) || oy[d] !== 10'(mv[d])) begin
        errors++;
        $display("FAIL px_xy dut%0d cyc %0d: got (%0d,%0d) want (%0d,%0d)", d, cyc, ox[d], oy[d], mh[d], mv[d]);
      end
      checks++;
      if (ovalid[d] !== (mh[d] < HV && mv[d] < VV) || ovb[d] !== (mv[d] >= VV)) begin
        errors++;
        $display("FAIL valid_vblank dut%0d cyc %0d: got %b/%b want %b/%b", d, cyc, ovalid[d], ovb[d], (mh[d] < HV && mv[d] < VV), (mv[d] >= VV));
      end
      checks++;
      if (ofs[d] !== (exp_tick && mh[d] == 0 && mv[d] == 0)) begin
        errors++;
        $display("FAIL frame_start dut%0d cyc %0d: got %b want %b", d, cyc, ofs[d], (exp_tick && mh[d] == 0 && mv[d] == 0));
      end

      // Measurements taken from the pins themselves, checked later by the scenario tasks.
      act = (ohs[d] === pol(d));
      if (act && !prev_hs[d]) begin
        if (hs_start[d] >= 0) hs_per[d] = cyc - hs_start[d];
        hs_start[d] = cyc;
        if (line_vis[d] > 0) begin
          lines_seen[d]++;
          if (line_vis[d] != HV || blank_run[d] != HF) bad_lines[d]++;
        end
        line_vis[d] = 0;
      end else if (!act && prev_hs[d]) begin
        hs_w[d] = cyc - hs_start[d];
      end
      prev_hs[d] = act;
      act = (ovs[d] === pol(d));
      if (act && !prev_vs[d]) begin
        if (vs_start[d] >= 0) vs_per[d] = cyc - vs_start[d];
        vs_start[d] = cyc;
      end else if (!act && prev_vs[d]) begin
        vs_w[d] = cyc - vs_start[d];
      end
      prev_vs[d] = act;
      if (ofs[d] === 1'b1) begin
        if (fs_start[d] >= 0) fs_per[d] = cyc - fs_start[d];
        fs_start[d] = cyc;
        fs_run[d]++;
        fs_cnt[d]++;
      end else if (fs_run[d] > 0) begin
        fs_wid[d] = fs_run[d];
        fs_run[d] = 0;
      end
      if (pend[d]) begin
        if (ocol[d] !== 12'h000) begin
          line_vis[d]++;
          blank_run[d] = 0;
          nz_cnt[d]++;
        end else begin
          blank_run[d]++;
        end
        if (held[d].th == 10'd0 && held[d].tv == 10'd5 && !r5_seen[d]) begin
          r5_col[d] = ocol[d];
          r5_seen[d] = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) step();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ocol[d] !== 12'h000 || ohs[d] !== ~pol(d) || ovs[d] !== ~pol(d)) begin
        errors++;
        $display("FAIL reset_pins dut%0d: got %h/%b/%b want 000/%b/%b", d, ocol[d], ohs[d], ovs[d], ~pol(d), ~pol(d));
      end
      checks++;
      if (ox[d] !== 10'd0 || oy[d] !== 10'd0 || ovalid[d] !== 1'b1 || ovb[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_req dut%0d: got x=%0d y=%0d valid=%b vblank=%b want 0 0 1 0", d, ox[d], oy[d], ovalid[d], ovb[d]);
      end
      checks++;
      if (otick[d] !== 1'b0 || ofs[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_pulses dut%0d: got tick=%b fs=%b want 0 0", d, otick[d], ofs[d]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_sync_timing(string tag);
    repeat (2 * HT * VT * 2 + 20) step();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (hs_per[d] !== HT * cdiv(d)) begin
        errors++;
        $display("FAIL %s hs_period dut%0d: got %0d want %0d", tag, d, hs_per[d], HT * cdiv(d));
      end
      checks++;
      if (hs_w[d] !== HSY * cdiv(d)) begin
        errors++;
        $display("FAIL %s hs_width dut%0d: got %0d want %0d", tag, d, hs_w[d], HSY * cdiv(d));
      end
      checks++;
      if (vs_per[d] !== HT * VT * cdiv(d)) begin
        errors++;
        $display("FAIL %s vs_period dut%0d: got %0d want %0d", tag, d, vs_per[d], HT * VT * cdiv(d));
      end
      checks++;
      if (vs_w[d] !== VSY * HT * cdiv(d)) begin
        errors++;
        $display("FAIL %s vs_width dut%0d: got %0d want %0d", tag, d, vs_w[d], VSY * HT * cdiv(d));
      end
      checks++;
      if (fs_per[d] !== HT * VT * cdiv(d) || fs_wid[d] !== 1 || fs_cnt[d] < 2) begin
        errors++;
        $display("FAIL %s frame_start dut%0d: got period %0d width %0d count %0d want %0d 1 >=2", tag, d, fs_per[d], fs_wid[d], fs_cnt[d], HT * VT * cdiv(d));
      end
    end
  endtask

  task automatic test_pixels();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (lines_seen[d] < VV || bad_lines[d] !== 0) begin
        errors++;
        $display("FAIL line_shape dut%0d: got %0d lines, %0d bad, want >=%0d lines, 0 bad", d, lines_seen[d], bad_lines[d], VV);
      end
      checks++;
      if (!r5_seen[d] || r5_col[d] !== 12'h05A) begin
        errors++;
        $display("FAIL row5_first dut%0d: got %h (seen %b) want 05a", d, r5_col[d], r5_seen[d]);
      end
    end
    checks++;
    if (otick[1] !== 1'b1) begin
      errors++;
      $display("FAIL tick_constant dut1: got %b want 1", otick[1]);
    end
  endtask

  task automatic test_midframe_reset();
    for (int i = 0; i < 2 * HT * VT * 2 && !(mh[0] == 10 && mv[0] == 4 && mdiv[0] == 0); i++) step();
    checks++;
    if (!(mh[0] == 10 && mv[0] == 4) || ocol[0] === 12'h000) begin
      errors++;
      $display("FAIL midframe_reach: got model (%0d,%0d) color %h want (10,4) non-zero color", mh[0], mv[0], ocol[0]);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ocol[d] !== 12'h000 || ohs[d] !== ~pol(d) || ovs[d] !== ~pol(d)) begin
        errors++;
        $display("FAIL midreset_pins dut%0d: got %h/%b/%b want 000/%b/%b", d, ocol[d], ohs[d], ovs[d], ~pol(d), ~pol(d));
      end
      checks++;
      if (ox[d] !== 10'd0 || oy[d] !== 10'd0) begin
        errors++;
        $display("FAIL midreset_counters dut%0d: got (%0d,%0d) want (0,0)", d, ox[d], oy[d]);
      end
    end
    test_sync_timing("after_reset");
    test_pixels();
  endtask

  task automatic test_white();
    rst = 1'b1;
    white = 1'b1;
    step();
    rst = 1'b0;
    repeat (2 * HT * VT * 2) step();
    nz_cnt[0] = 0;
    nz_cnt[1] = 0;
    repeat (HT * VT * 2) step();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (nz_cnt[d] !== HV * VV * (3 - cdiv(d))) begin
        errors++;
        $display("FAIL white_count dut%0d: got %0d want %0d", d, nz_cnt[d], HV * VV * (3 - cdiv(d)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_sync_timing("free_run");
    test_pixels();
    test_midframe_reset();
    test_white();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
